// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan block: digit count, blank codes, hex decode table.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg7_pkg;

    localparam int          SEG7_DIGITS = 8;
    localparam logic [6:0]  SEG_OFF     = 7'h7F;
    localparam logic [7:0]  AN_OFF      = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns, indexed by nibble value (entry 15 written first).
    localparam logic [15:0][6:0] HEX_SEG_TBL = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg7_scan_hex_to_seg7.sv
// Combinational 4-bit nibble to active-low 7-segment pattern decode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   i_nib  4-bit hex digit
//   o_seg  segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG_TBL[i_nib];

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexes a latched 32-bit word as 8 hex digits on a common-anode display.
// Latency: value_valid to visible change 1 clk; blank takes effect at the next edge.
// Backpressure: none; value_valid is a strobe and is accepted every cycle it is high.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   value, value_valid   word to display and its latch strobe
//   dp_mask, blank       per-digit decimal points and global blank, both sampled live
//   an, seg, dp          registered active-low digit enables, segments, decimal point
//
// Build option: define SEG7_LZ_BLANK_EN to blank digits above the most significant
// nonzero nibble (digit 0 always lit).
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] value,
    input  logic        value_valid,
    input  logic [7:0]  dp_mask,
    input  logic        blank,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    // Clocks per digit slot; must be at least 2.
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [31:0]   r_val;

    logic          w_wrap;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    w_idx_next;
    logic [31:0]   w_val_next;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg;
    logic          w_digit_on;

    assign w_wrap     = (r_cnt == CW'(DIV - 1));
    assign w_cnt_next = w_wrap ? '0 : r_cnt + 1'b1;
    // 3-bit index wraps 7 -> 0 on its own.
    assign w_idx_next = w_wrap ? r_idx + 3'd1 : r_idx;
    // Outputs are built from next-state values so a strobe coinciding with the
    // digit change already shows the new word on the new digit.
    assign w_val_next = value_valid ? value : r_val;
    assign w_nib      = w_val_next[{w_idx_next, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

`ifdef SEG7_LZ_BLANK_EN
    logic [2:0] w_msn;

    // Highest nonzero nibble; stays 0 for an all-zero word so digit 0 remains lit.
    always_comb begin
        w_msn = 3'd0;
        for (int i = 1; i < SEG7_DIGITS; i++) begin
            if (w_val_next[4*i +: 4] != 4'd0) begin
                w_msn = 3'(i);
            end
        end
    end

    assign w_digit_on = (w_idx_next <= w_msn);
`else
    assign w_digit_on = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
            r_val <= 32'd0;
        end else begin
            r_cnt <= w_cnt_next;
            r_idx <= w_idx_next;
            r_val <= w_val_next;
        end
    end

    // Blank only gates the outputs; the scan keeps running underneath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else if (blank || !w_digit_on) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= ~(8'h01 << w_idx_next);
            seg <= w_seg;
            dp  <= ~dp_mask[w_idx_next];
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with CLK_HZ=8, SCAN_HZ=2 (4 clocks per digit).
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_scan;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] value;
    logic        value_valid;
    logic [7:0]  dp_mask;
    logic        blank;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg7_scan #(.CLK_HZ(8), .SCAN_HZ(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .value_valid (value_valid),
        .dp_mask     (dp_mask),
        .blank       (blank),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] nib;
        logic [6:0] seg;
    } dec_vec_t;

    dec_vec_t    tbl [16];
    logic [15:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    // Reference scan state
    int          m_cnt;
    int          m_idx;
    logic [31:0] m_val;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic bit lit(input logic [31:0] v, input int di);
`ifdef SEG7_LZ_BLANK_EN
        int top;
        top = 0;
        for (int k = 0; k < 8; k++) if (((v >> (4*k)) & 32'hF) != 0) top = k;
        return di <= top;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_cnt = 0;
        m_idx = 0;
        m_val = 32'd0;
        exp_q.delete();
    endtask

    // Predict, clock, compare.
    task automatic step(input string name);
        int          ni;
        logic [31:0] nv;
        logic [15:0] e;
        logic [7:0]  an_e;
        ni = (m_cnt == DIV - 1) ? (m_idx + 1) % 8 : m_idx;
        nv = value_valid ? value : m_val;
        e  = {8'hFF, 7'h7F, 1'b1};
        if (!blank && lit(nv, ni)) begin
            an_e = 8'hFF;
            an_e[ni] = 1'b0;
            e = {an_e, tbl[(nv >> (4*ni)) & 32'hF].seg, ~dp_mask[ni]};
        end
        exp_q.push_back(e);
        @(posedge clk);
        m_cnt = (m_cnt + 1) % DIV;
        m_idx = ni;
        m_val = nv;
        cyc++;
        #1;
        chk(name, {an, seg, dp}, exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first_fe;
        int          second_fe;
        bit          found;
        logic [7:0]  prev_an;
        logic [7:0]  lit_mask;

        tbl[0]  = '{4'h0, 7'h40}; tbl[1]  = '{4'h1, 7'h79};
        tbl[2]  = '{4'h2, 7'h24}; tbl[3]  = '{4'h3, 7'h30};
        tbl[4]  = '{4'h4, 7'h19}; tbl[5]  = '{4'h5, 7'h12};
        tbl[6]  = '{4'h6, 7'h02}; tbl[7]  = '{4'h7, 7'h78};
        tbl[8]  = '{4'h8, 7'h00}; tbl[9]  = '{4'h9, 7'h10};
        tbl[10] = '{4'hA, 7'h08}; tbl[11] = '{4'hB, 7'h03};
        tbl[12] = '{4'hC, 7'h46}; tbl[13] = '{4'hD, 7'h21};
        tbl[14] = '{4'hE, 7'h06}; tbl[15] = '{4'hF, 7'h0E};

        // Reset held across several edges
        rst_n = 1'b0; value = 32'd0; value_valid = 1'b0; dp_mask = 8'h00; blank = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
        rst_n = 1'b1;

        // Zero word: scan FE..7F with seg=40
        value = 32'd0; value_valid = 1'b1;
        step("zero_first");
        chk("zero_first_digit0", {an, seg}, {8'hFE, 7'h40});
        value_valid = 1'b0;
        for (int i = 0; i < 40; i++) step("zero_scan");

        // Decode table: every digit carries the same nibble
        for (int i = 0; i < 16; i++) begin
            value = {8{tbl[i].nib}}; value_valid = 1'b1;
            step("decode_latch");
            value_valid = 1'b0;
            chk("decode_tbl", {9'd0, seg}, {9'd0, tbl[i].seg});
        end

        // Sweep word and frame period
        value = 32'hFEDC_BA98; value_valid = 1'b1;
        step("sweep_latch");
        value_valid = 1'b0;
        first_fe = -1; second_fe = -1; prev_an = an;
        for (int i = 0; i < 80; i++) begin
            step("sweep_scan");
            if (an == 8'hFE && prev_an != 8'hFE) begin
                if (first_fe < 0) first_fe = cyc;
                else if (second_fe < 0) second_fe = cyc;
            end
            prev_an = an;
        end
        chk("frame_period", 16'(second_fe - first_fe), 16'd32);

        // Latch on the 0 -> 1 wrap edge
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (m_idx == 0 && m_cnt == DIV - 1) found = 1'b1;
            else step("wait_wrap");
        end
        chk("wait_wrap_bound", 16'(found), 16'd1);
        value = 32'h0000_0001; value_valid = 1'b1;
        step("latch_wrap");
        chk("latch_wrap_digit1", {an, seg}, {8'hFD, 7'h40});
        value_valid = 1'b0;
        value = 32'h1234_5678;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step("no_valid_hold");
            if (an == 8'hFE && !found) begin
                found = 1'b1;
                chk("digit0_shows_1", {9'd0, seg}, {9'd0, 7'h79});
            end
        end
        chk("digit0_seen", 16'(found), 16'd1);

        // Decimal point on digit 2 only
        dp_mask = 8'h04;
        for (int i = 0; i < 32; i++) begin
            step("dp_scan");
            chk("dp_only_digit2", 16'(dp), 16'(an != 8'hFB));
        end

        // Blank for 10 clocks, then resume at free-running position
        blank = 1'b1;
        step("blank_first");
        chk("blank_an_off", {8'd0, an}, {8'd0, 8'hFF});
        for (int i = 0; i < 9; i++) step("blank_hold");
        blank = 1'b0;
        step("blank_resume");
        chk("blank_resume_idx", {8'd0, an}, {8'd0, ~(8'h01 << m_idx)});
        dp_mask = 8'h00;

        // Async reset mid-frame at idx 5
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            step("wait_idx5");
            if (m_idx == 5) found = 1'b1;
        end
        chk("wait_idx5_bound", 16'(found), 16'd1);
        rst_n = 1'b0;
        #2;
        chk("async_reset", {an, seg, dp}, {8'hFF, 7'h7F, 1'b1});
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step("after_reset");
        chk("after_reset_digit0", {8'd0, an}, {8'd0, 8'hFE});
        for (int i = 0; i < 10; i++) step("after_reset_scan");

`ifdef SEG7_LZ_BLANK_EN
        value = 32'h0000_0A05; value_valid = 1'b1;
        step("lz_latch");
        value_valid = 1'b0;
        lit_mask = 8'h00;
        for (int i = 0; i < 36; i++) begin
            step("lz_scan");
            lit_mask = lit_mask | ~an;
        end
        chk("lz_lit_0a05", {8'd0, lit_mask}, {8'd0, 8'h07});

        value = 32'd0; value_valid = 1'b1;
        step("lz_zero_latch");
        value_valid = 1'b0;
        lit_mask = 8'h00;
        for (int i = 0; i < 36; i++) begin
            step("lz_zero_scan");
            lit_mask = lit_mask | ~an;
            if (an == 8'hFE) chk("lz_zero_seg", {9'd0, seg}, {9'd0, 7'h40});
        end
        chk("lz_lit_zero", {8'd0, lit_mask}, {8'd0, 8'h01});
`else
        lit_mask = 8'h00;
        for (int i = 0; i < 36; i++) begin
            step("nolz_scan");
            lit_mask = lit_mask | ~an;
        end
        chk("nolz_all_lit", {8'd0, lit_mask}, {8'd0, 8'hFF});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Downstream display stage of the board top level: consumes the 32-bit word selected by the display control path (RAM word at the display address, PC, or cycle count, chosen by the display opcode).
- Time-multiplexes that word as 8 hex digits onto the board's common-anode seven-segment display.
- Holds a latched copy of the word so the display never tears mid-scan.

Parameters:
- CLK_HZ, 100000000, input clock frequency in Hz.
- SCAN_HZ, 1000, digit-slot rate in Hz. DIV = CLK_HZ/SCAN_HZ clocks per digit; DIV >= 2 is required.
- DIGITS, 8, number of digits scanned. Fixed at 8 to match the 32-bit value.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- value  input  32  word to display; digit i shows value[4i+3:4i].
- value_valid  input  1  single-cycle strobe; latches value.
- dp_mask  input  8  bit i set lights the decimal point of digit i; sampled live.
- blank  input  1  1 turns all digits off; sampled live.
- an  output  8  digit enables, active-low, one-hot-low when lit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset (async assert, sync-released by the first clk edge):
  - an=8'hFF, seg=7'h7F, dp=1.
  - Slot counter cnt=0, digit index idx=0, latched word val_q=0.
- Slot counter:
  - cnt counts 0..DIV-1 every clk.
  - At cnt==DIV-1, cnt wraps to 0 and idx increments mod 8 (7 -> 0).
- Latch: val_q <= value on any cycle with value_valid=1. Holding value_valid high latches every cycle.
- Outputs are registered from next-state values (idx_next, val_q_next, live dp_mask and blank):
  - an = ~(1<<idx_next).
  - seg = hex decode of nibble idx_next of val_q_next.
  - dp = ~dp_mask[idx_next].
  - The first edge after reset shows digit 0. Each digit is held exactly DIV cycles, and a full frame is 8*DIV cycles.
- Latency: the value_valid cycle is 1 clk to the visible change on the current digit. If value_valid coincides with the idx wrap edge, the new word is used for the new digit.
- blank=1: registered an=8'hFF, seg=7'h7F, dp=1 from the next edge. cnt and idx keep running, so resuming from blank lands on the current scan position.
- Hex decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (all hex).
- Reset asserted mid-scan: outputs go to reset values immediately (asynchronously). The scan restarts at digit 0.

Optional Feature:
- Macro: SEG7_LZ_BLANK_EN.
- Defined: leading-zero blanking. Any digit above the most significant nonzero nibble of val_q has an=1, seg=7F, dp=1 for its slot. Digit 0 is always lit, so val_q=0 shows a single "0". The dp of a blanked digit is also off.
- Undefined: all 8 digits always shown, with zeros.

Decomposition:
- Shared package seg7_pkg:
  - SEG7_DIGITS=8.
  - The 16-entry active-low hex-to-segment constant table.
  - SEG_OFF=7'h7F and AN_OFF=8'hFF.
- One natural sub-module: hex_to_seg7, a combinational 4-bit to 7-bit decode using the package table, instantiated once on the selected nibble.
- Counter, index, latch, leading-zero logic and output registers stay in seg7_scan.

Test Plan (CLK_HZ=8, SCAN_HZ=2, so DIV=4):
- Reset check: hold rst_n=0 -> an=FF, seg=7F, dp=1. Release rst_n, then value=32'h0000_0000 with value_valid pulsed -> an cycles FE,FD,...,7F, each for 4 clks, with seg=40 throughout.
- Decode sweep: value=32'hFEDC_BA98 latched -> digit 0 shows seg=00 (8), digit 1 seg=10, digit 2 seg=08 (A), digit 7 seg=0E (F). Frame repeats with 32 clks between appearances of digit 0.
- Latch timing: value_valid with value=32'h1 on the clk where idx wraps 0->1 -> digit 1 shows 40 and the next digit 0 shows 79. Changing value without value_valid -> display unchanged.
- dp/blank: dp_mask=8'h04 -> dp=0 only while an=FB. Assert blank for 10 clks -> an=FF after 1 clk; deassert -> resumes at the idx that the free-running scan has reached.
- Async reset mid-frame at idx=5 -> outputs go to reset values before the next edge, and the first edge after release shows an=FE.
- SEG7_LZ_BLANK_EN defined, value=32'h0000_0A05 -> digits 0-2 lit (05, A), digits 3-7 an=1. With value=0 -> only digit 0 lit, seg=40.
